// File: rtl/mcu_cmd_pkg.sv
// mcu_cmd_pkg
// Shared encodings for the MCU configuration-mode command path: command
// types, error codes, decoder FSM states and the default head-byte
// constants, so the decoder and the transceiver controller agree on values.
package mcu_cmd_pkg;

  typedef enum logic [2:0] {
    CMD_CFG_SAVE = 3'd0,
    CMD_CFG_TEMP = 3'd1,
    CMD_RET_CFG  = 3'd2,
    CMD_RET_VER  = 3'd3,
    CMD_RESET    = 3'd4
  } cmd_type_e;

  typedef enum logic [1:0] {
    ERR_UNKNOWN  = 2'd0,
    ERR_MISMATCH = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_OVERRUN  = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PARAM  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam logic [7:0] HEAD_CFG_SAVE = 8'hC0;
  localparam logic [7:0] HEAD_CFG_TEMP = 8'hC2;
  localparam logic [7:0] HEAD_RET_CFG  = 8'hC1;
  localparam logic [7:0] HEAD_RET_VER  = 8'hC3;
  localparam logic [7:0] HEAD_RESET    = 8'hC4;

  // Number of identical bytes that make up a C1/C3/C4 request.
  localparam int REPEAT_COUNT = 3;

endpackage

// File: rtl/byte_gap_timer.sv
// byte_gap_timer
// Counts idle clocks between bytes of a frame. The count clears whenever
// clr is high; otherwise it advances on each en cycle. expire is a
// combinational one-cycle strobe raised on the LIMIT-th consecutive counted
// cycle, after which the count restarts from zero.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - clear the count (byte accepted / not inside a frame)
//   en        - count this cycle
//   expire    - LIMIT idle cycles have elapsed
// WIDTH must satisfy 2**WIDTH > LIMIT.
module byte_gap_timer #(
  parameter int LIMIT = 50000,
  parameter int WIDTH = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, otherwise a
    // path that skips the assignment infers a latch.
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == WIDTH'(LIMIT - 1)) begin
        expire = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use <= so every flop samples pre-edge values;
    // = here would create order-dependent simulation races.
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mcu_cmd_decoder.sv
// mcu_cmd_decoder
// Parses configuration-mode UART bytes into command frames:
//   C0/C2 + CONFIG_PARAM_BYTES parameter bytes -> CFG_SAVE / CFG_TEMP
//   C1/C3/C4 repeated three times              -> RET_CFG / RET_VER / RESET
// One decoded command is offered at a time on cmd_valid/cmd_ready.
// All outputs are registered: cmd_valid and err_valid rise on the cycle
// after the byte strobe (or timeout expiry) that caused them.
// Ports:
//   internal_clk, rst   - clock, synchronous active-high reset
//   cmd_enable          - configuration mode; bytes ignored when low
//   rx_flag, rx_data    - received byte strobe and data
//   cmd_valid/cmd_ready - command handshake
//   cmd_type            - cmd_type_e encoding
//   cfg_params          - parameter bytes, first received in the MSBs
//   busy                - frame in progress or command pending
//   err_valid, err_code - one-cycle error strobe, err_code_e encoding
//   err_count           - saturating error count (only with CMD_ERR_COUNT_EN)
// Optional feature macro: CMD_ERR_COUNT_EN.
module mcu_cmd_decoder
  import mcu_cmd_pkg::*;
#(
  parameter int                    DATA_WIDTH         = 8,
  parameter logic [DATA_WIDTH-1:0] HEAD_DETECT_1      = DATA_WIDTH'(HEAD_CFG_SAVE),
  parameter logic [DATA_WIDTH-1:0] HEAD_DETECT_2      = DATA_WIDTH'(HEAD_CFG_TEMP),
  parameter logic [DATA_WIDTH-1:0] RET_CONFIG_DETECT  = DATA_WIDTH'(HEAD_RET_CFG),
  parameter logic [DATA_WIDTH-1:0] RET_VERSION_DETECT = DATA_WIDTH'(HEAD_RET_VER),
  parameter logic [DATA_WIDTH-1:0] RESET_DETECT       = DATA_WIDTH'(HEAD_RESET),
  parameter int                    CONFIG_PARAM_BYTES = 5,
  parameter int                    INTER_BYTE_TIMEOUT = 50000,
  parameter int                    TIMEOUT_WIDTH      = 20
) (
  input  logic                                   internal_clk,
  input  logic                                   rst,
  input  logic                                   cmd_enable,
  input  logic                                   rx_flag,
  input  logic [DATA_WIDTH-1:0]                  rx_data,
  output logic                                   cmd_valid,
  input  logic                                   cmd_ready,
  output logic [2:0]                             cmd_type,
  output logic [CONFIG_PARAM_BYTES*DATA_WIDTH-1:0] cfg_params,
  output logic                                   busy,
  output logic                                   err_valid,
  output logic [1:0]                             err_code
`ifdef CMD_ERR_COUNT_EN
  ,
  output logic [7:0]                             err_count
`endif
);

  localparam int CFG_W  = CONFIG_PARAM_BYTES * DATA_WIDTH;
  localparam int BCNT_W = (CONFIG_PARAM_BYTES > 1) ? $clog2(CONFIG_PARAM_BYTES) : 1;
  localparam logic [BCNT_W-1:0] LAST_IDX = BCNT_W'(CONFIG_PARAM_BYTES - 1);
  localparam logic [1:0]        LAST_REP = 2'(REPEAT_COUNT - 1);

  state_e                state_q,      state_d;
  logic [DATA_WIDTH-1:0] head_q,       head_d;
  logic [BCNT_W-1:0]     byte_cnt_q,   byte_cnt_d;
  logic [1:0]            rep_cnt_q,    rep_cnt_d;
  cmd_type_e             cmd_type_q,   cmd_type_d;
  logic [CFG_W-1:0]      cfg_params_q, cfg_params_d;
  logic                  cmd_valid_q,  cmd_valid_d;
  logic                  err_valid_q,  err_valid_d;
  err_code_e             err_code_q,   err_code_d;

  logic byte_in;
  logic in_frame;
  logic gap_clr, gap_expire;
  logic ev_unknown, ev_mismatch, ev_timeout, ev_overrun;

  assign byte_in  = rx_flag & cmd_enable;
  assign in_frame = (state_q == ST_PARAM) || (state_q == ST_REPEAT);
  // A byte arriving on the expiry cycle clears the timer, so it wins.
  assign gap_clr  = ~in_frame | ~cmd_enable | rx_flag;

  byte_gap_timer #(
    .LIMIT (INTER_BYTE_TIMEOUT),
    .WIDTH (TIMEOUT_WIDTH)
  ) u_gap_timer (
    .clk    (internal_clk),
    .rst    (rst),
    .clr    (gap_clr),
    .en     (in_frame),
    .expire (gap_expire)
  );

  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    byte_cnt_d   = byte_cnt_q;
    rep_cnt_d    = rep_cnt_q;
    cmd_type_d   = cmd_type_q;
    cfg_params_d = cfg_params_q;
    cmd_valid_d  = cmd_valid_q;
    ev_unknown   = 1'b0;
    ev_mismatch  = 1'b0;
    ev_timeout   = 1'b0;
    ev_overrun   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (byte_in) begin
          if (rx_data == HEAD_DETECT_1 || rx_data == HEAD_DETECT_2) begin
            state_d    = ST_PARAM;
            byte_cnt_d = '0;
            cmd_type_d = (rx_data == HEAD_DETECT_1) ? CMD_CFG_SAVE : CMD_CFG_TEMP;
          end else if (rx_data == RET_CONFIG_DETECT || rx_data == RET_VERSION_DETECT ||
                       rx_data == RESET_DETECT) begin
            state_d    = ST_REPEAT;
            head_d     = rx_data;
            rep_cnt_d  = 2'd1;
            cmd_type_d = (rx_data == RET_CONFIG_DETECT)  ? CMD_RET_CFG :
                         (rx_data == RET_VERSION_DETECT) ? CMD_RET_VER : CMD_RESET;
          end else begin
            ev_unknown = 1'b1;
          end
        end
      end

      ST_PARAM: begin
        if (!cmd_enable) begin
          state_d = ST_IDLE;
        end else if (rx_flag) begin
          cfg_params_d[(CONFIG_PARAM_BYTES - 1 - int'(byte_cnt_q)) * DATA_WIDTH +: DATA_WIDTH]
            = rx_data;
          if (byte_cnt_q == LAST_IDX) begin
            state_d     = ST_HOLD;
            cmd_valid_d = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + BCNT_W'(1);
          end
        end else if (gap_expire) begin
          state_d    = ST_IDLE;
          ev_timeout = 1'b1;
        end
      end

      ST_REPEAT: begin
        if (!cmd_enable) begin
          state_d = ST_IDLE;
        end else if (rx_flag) begin
          // A mismatching byte is consumed by the error; it never starts a frame.
          if (rx_data != head_q) begin
            state_d     = ST_IDLE;
            ev_mismatch = 1'b1;
          end else if (rep_cnt_q == LAST_REP) begin
            state_d     = ST_HOLD;
            cmd_valid_d = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + 2'd1;
          end
        end else if (gap_expire) begin
          state_d    = ST_IDLE;
          ev_timeout = 1'b1;
        end
      end

      ST_HOLD: begin
        // The pending command is untouched; only the strobe reports the drop.
        if (byte_in) ev_overrun = 1'b1;
        if (cmd_valid_q && cmd_ready) begin
          state_d     = ST_IDLE;
          cmd_valid_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Lowest code wins if events ever coincide.
  always_comb begin
    err_valid_d = ev_unknown | ev_mismatch | ev_timeout | ev_overrun;
    err_code_d  = err_code_q;
    if      (ev_unknown)  err_code_d = ERR_UNKNOWN;
    else if (ev_mismatch) err_code_d = ERR_MISMATCH;
    else if (ev_timeout)  err_code_d = ERR_TIMEOUT;
    else if (ev_overrun)  err_code_d = ERR_OVERRUN;
  end

  always_ff @(posedge internal_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      head_q       <= '0;
      byte_cnt_q   <= '0;
      rep_cnt_q    <= '0;
      cmd_type_q   <= CMD_CFG_SAVE;
      // NOTE: the parameter register is a visible output that must read 0
      // after reset, so unlike a plain data buffer it is reset.
      cfg_params_q <= '0;
      cmd_valid_q  <= 1'b0;
      err_valid_q  <= 1'b0;
      err_code_q   <= ERR_UNKNOWN;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      byte_cnt_q   <= byte_cnt_d;
      rep_cnt_q    <= rep_cnt_d;
      cmd_type_q   <= cmd_type_d;
      cfg_params_q <= cfg_params_d;
      cmd_valid_q  <= cmd_valid_d;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_type   = cmd_type_q;
  assign cfg_params = cfg_params_q;
  assign busy       = (state_q != ST_IDLE) | cmd_valid_q;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;

`ifdef CMD_ERR_COUNT_EN
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (err_valid_d && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge internal_clk) begin
    if (rst) err_count_q <= '0;
    else     err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

  a_single_error_event : assert property (@(posedge internal_clk) disable iff (rst)
    $onehot0({ev_unknown, ev_mismatch, ev_timeout, ev_overrun}));

endmodule

// File: tb/tb_mcu_cmd_decoder.sv
// tb_mcu_cmd_decoder
// Directed scenarios followed by randomized frames, every cycle compared
// against a frame-level reference model (byte queue + idle-gap counter).
module tb_mcu_cmd_decoder;

  localparam int LIMIT = 40;
  localparam int NB    = 5;

  logic        internal_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_enable = 1'b1;
  logic        rx_flag = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        cmd_ready = 1'b0;
  logic        cmd_valid;
  logic [2:0]  cmd_type;
  logic [39:0] cfg_params;
  logic        busy;
  logic        err_valid;
  logic [1:0]  err_code;
`ifdef CMD_ERR_COUNT_EN
  logic [7:0]  err_count;
`endif

  always #5 internal_clk = ~internal_clk;

  mcu_cmd_decoder #(
    .INTER_BYTE_TIMEOUT (LIMIT)
  ) dut (
    .internal_clk (internal_clk),
    .rst          (rst),
    .cmd_enable   (cmd_enable),
    .rx_flag      (rx_flag),
    .rx_data      (rx_data),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_type     (cmd_type),
    .cfg_params   (cfg_params),
    .busy         (busy),
    .err_valid    (err_valid),
    .err_code     (err_code)
`ifdef CMD_ERR_COUNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: bytes of the frame in progress, idle cycles since the
  // last accepted byte, and the pending command.
  logic [7:0]  fq[$];
  int          gap = 0;
  bit          pend = 0;
  logic [2:0]  m_type = 3'd0;
  logic [39:0] m_cfg = '0;
  bit          m_err = 0;
  logic [1:0]  m_code = 2'd0;
  logic [7:0]  m_ecnt = 8'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic flag_err(input logic [1:0] code);
    m_err  = 1;
    m_code = code;
    if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
  endtask

  task automatic model_step();
    int idx;
    m_err = 0;
    if (rst) begin
      fq.delete(); gap = 0; pend = 0;
      m_type = 3'd0; m_cfg = '0; m_code = 2'd0; m_ecnt = 8'd0;
    end else if (pend) begin
      if (rx_flag && cmd_enable) flag_err(2'd3);
      if (cmd_ready) pend = 0;
    end else if (fq.size() == 0) begin
      gap = 0;
      if (rx_flag && cmd_enable) begin
        if (rx_data == 8'hC0 || rx_data == 8'hC2) begin
          fq.push_back(rx_data);
          m_type = (rx_data == 8'hC0) ? 3'd0 : 3'd1;
        end else if (rx_data inside {8'hC1, 8'hC3, 8'hC4}) begin
          fq.push_back(rx_data);
          m_type = (rx_data == 8'hC1) ? 3'd2 : (rx_data == 8'hC3) ? 3'd3 : 3'd4;
        end else begin
          flag_err(2'd0);
        end
      end
    end else if (!cmd_enable) begin
      fq.delete(); gap = 0;
    end else if (rx_flag) begin
      gap = 0;
      if (fq[0] == 8'hC0 || fq[0] == 8'hC2) begin
        idx = fq.size() - 1;
        m_cfg[(NB - 1 - idx) * 8 +: 8] = rx_data;
        fq.push_back(rx_data);
        if (fq.size() == NB + 1) begin pend = 1; fq.delete(); end
      end else if (rx_data == fq[0]) begin
        fq.push_back(rx_data);
        if (fq.size() == 3) begin pend = 1; fq.delete(); end
      end else begin
        flag_err(2'd1); fq.delete();
      end
    end else begin
      gap++;
      if (gap == LIMIT) begin flag_err(2'd2); fq.delete(); gap = 0; end
    end
  endtask

  // One clock: model consumes the inputs seen at the edge, DUT outputs are
  // compared 1 ns later.
  task automatic tick();
    @(posedge internal_clk);
    model_step();
    #1;
    check("cmd_valid",  cmd_valid,  pend);
    check("busy",       busy,       pend || fq.size() != 0);
    check("err_valid",  err_valid,  m_err);
    check("err_code",   err_code,   m_code);
    check("cmd_type",   cmd_type,   m_type);
    check("cfg_params", cfg_params, m_cfg);
`ifdef CMD_ERR_COUNT_EN
    check("err_count",  err_count,  m_ecnt);
`endif
  endtask

  task automatic send(input logic [7:0] b);
    rx_flag = 1'b1;
    rx_data = b;
    tick();
    rx_flag = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic rnd_cycle(input bit v, input logic [7:0] d);
    rx_flag    = v;
    rx_data    = v ? d : 8'($urandom);
    cmd_ready  = ($urandom_range(0, 9) < 6);
    cmd_enable = ($urandom_range(0, 49) != 0);
    rst        = ($urandom_range(0, 299) == 0);
    tick();
    rst        = 1'b0;
    rx_flag    = 1'b0;
    cmd_enable = 1'b1;
  endtask

  logic [7:0] fr[$];
  logic [7:0] heads[3] = '{8'hC1, 8'hC3, 8'hC4};
  int kind, long_pos;

  initial begin
    // Reset state
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check("rst_valid", cmd_valid, 1'b0);
    check("rst_busy",  busy,      1'b0);
    idle(1);

    // C0 load frame held until ready
    cmd_ready = 1'b0;
    send(8'hC0); send(8'h00); send(8'h01); send(8'h1A); send(8'h17);
    check("c0_not_yet", cmd_valid, 1'b0);
    send(8'h44);
    check("c0_valid",  cmd_valid,  1'b1);
    check("c0_type",   cmd_type,   3'd0);
    check("c0_params", cfg_params, 40'h00011A1744);
    idle(3);
    check("c0_held", cmd_valid, 1'b1);
    cmd_ready = 1'b1;
    tick();
    check("c0_cleared", cmd_valid, 1'b0);

    // C3 x3 with ready tied high: single valid cycle
    send(8'hC3); send(8'hC3); send(8'hC3);
    check("c3_valid", cmd_valid, 1'b1);
    check("c3_type",  cmd_type,  3'd3);
    check("c3_params_kept", cfg_params, 40'h00011A1744);
    tick();
    check("c3_valid_drop", cmd_valid, 1'b0);
    check("c3_busy_drop",  busy,      1'b0);

    // Mismatch, then unknown byte
    send(8'hC1); send(8'hC1); send(8'hC4);
    check("mm_err",   err_valid, 1'b1);
    check("mm_code",  err_code,  2'd1);
    send(8'h55);
    check("unk_err",  err_valid, 1'b1);
    check("unk_code", err_code,  2'd0);
    tick();
    check("unk_pulse", err_valid, 1'b0);

    // Timeout, then recovery with C4 x3
    send(8'hC2); send(8'h00); send(8'h01);
    idle(LIMIT - 1);
    check("to_early", err_valid, 1'b0);
    tick();
    check("to_err",  err_valid, 1'b1);
    check("to_code", err_code,  2'd2);
    send(8'hC4); send(8'hC4); send(8'hC4);
    check("c4_type", cmd_type, 3'd4);
    tick();

    // Byte on the expiry cycle wins
    cmd_ready = 1'b0;
    send(8'hC2); send(8'h10);
    idle(LIMIT - 1);
    send(8'h20);
    check("to_race_err",  err_valid, 1'b0);
    check("to_race_busy", busy,      1'b1);
    send(8'h30); send(8'h40); send(8'h50);
    check("c2_type",   cmd_type,   3'd1);
    check("c2_params", cfg_params, 40'h1020304050);

    // Overrun while holding
    send(8'h12);
    check("ovr_err",    err_valid,  1'b1);
    check("ovr_code",   err_code,   2'd3);
    check("ovr_params", cfg_params, 40'h1020304050);
    check("ovr_valid",  cmd_valid,  1'b1);
    cmd_ready = 1'b1;
    tick();
    check("ovr_done", cmd_valid, 1'b0);

    // Reset mid-frame, then enable drop mid-frame
    send(8'hC0); send(8'h00); send(8'h01);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_busy", busy, 1'b0);
    send(8'hC4); send(8'hC4);
    cmd_enable = 1'b0; tick(); cmd_enable = 1'b1;
    check("en_drop_busy", busy,      1'b0);
    check("en_drop_err",  err_valid, 1'b0);
    send(8'hC1); send(8'hC1); send(8'hC1);
    check("after_abort_type", cmd_type, 3'd2);
    tick();

    // Randomized frames
    for (int it = 0; it < 250; it++) begin
      fr.delete();
      kind = $urandom_range(0, 9);
      if (kind <= 2) begin
        fr.push_back($urandom_range(0, 1) ? 8'hC0 : 8'hC2);
        repeat (NB) fr.push_back(8'($urandom));
      end else if (kind <= 5) begin
        repeat (3) fr.push_back(heads[$urandom_range(0, 2)]);
        if ($urandom_range(0, 1) == 0) begin
          fr[1] = fr[0];
          fr[2] = fr[0];
        end
      end else if (kind == 6) begin
        fr.push_back(8'($urandom));
      end else if (kind == 7) begin
        fr.push_back(8'hC0);
        repeat ($urandom_range(0, 3)) fr.push_back(8'($urandom));
      end else begin
        fr.push_back(8'($urandom_range(8'hBF, 8'hC5)));
      end
      long_pos = ($urandom_range(0, 7) == 0) ? $urandom_range(0, fr.size() - 1) : -1;
      foreach (fr[i]) begin
        rnd_cycle(1'b1, fr[i]);
        repeat ($urandom_range(0, 2)) rnd_cycle(1'b0, 8'h00);
        if (i == long_pos) repeat ($urandom_range(LIMIT - 2, LIMIT + 1)) rnd_cycle(1'b0, 8'h00);
      end
    end

`ifdef CMD_ERR_COUNT_EN
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (300) send(8'h55);
    check("err_count_sat", err_count, 8'd255);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mcu_cmd_decoder.md
Name: mcu_cmd_decoder

Overview:
- Parses the byte stream from the MCU-side UART receiver in configuration mode (M1=M0=1) into complete command frames.
- Recognised frames: C0/C2 parameter loads with 5 parameter bytes; C1/C3/C4 triple-repeat requests.
- Presents one decoded command at a time to the transceiver controller over a valid/ready handshake.
- Reports malformed frames, inter-byte timeouts and overruns on a one-cycle error strobe.

Parameters:
- DATA_WIDTH, 8, byte width of the UART data bus
- HEAD_DETECT_1, 8'hC0, load config and save
- HEAD_DETECT_2, 8'hC2, load config without save
- RET_CONFIG_DETECT, 8'hC1, return-config request byte
- RET_VERSION_DETECT, 8'hC3, return-version request byte
- RESET_DETECT, 8'hC4, module-reset request byte
- CONFIG_PARAM_BYTES, 5, parameter bytes following C0/C2
- INTER_BYTE_TIMEOUT, 50000, max idle clocks between bytes inside a frame
- TIMEOUT_WIDTH, 20, counter width; must satisfy 2^TIMEOUT_WIDTH > INTER_BYTE_TIMEOUT

Ports:
- internal_clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_enable  in  1  high only in configuration mode (M1_sync & M0_sync)
- rx_flag  in  1  one-cycle strobe: rx_data holds a new byte
- rx_data  in  DATA_WIDTH  received byte
- cmd_valid  out  1  decoded command pending
- cmd_ready  in  1  controller accepts the command
- cmd_type  out  3  0=CFG_SAVE, 1=CFG_TEMP, 2=RET_CFG, 3=RET_VER, 4=RESET
- cfg_params  out  CONFIG_PARAM_BYTES*DATA_WIDTH  first received param byte in the MSBs
- busy  out  1  (state != IDLE) | cmd_valid
- err_valid  out  1  one-cycle error strobe
- err_code  out  2  0=UNKNOWN, 1=MISMATCH, 2=TIMEOUT, 3=OVERRUN

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - all outputs 0; state=IDLE; counters 0.
  - Reset mid-frame discards the partial frame with no error.
- Bytes are sampled only on cycles with rx_flag=1.
- FSM states: IDLE, PARAM, REPEAT, HOLD.
- IDLE:
  - C0 -> PARAM; type=CFG_SAVE; byte_cnt=0.
  - C2 -> PARAM; type=CFG_TEMP; byte_cnt=0.
  - C1/C3/C4 -> REPEAT; head latched; rep_cnt=1.
  - Any other byte -> stay in IDLE; err UNKNOWN.
- PARAM:
  - Each byte is written into slot byte_cnt; byte_cnt increments.
  - On byte index CONFIG_PARAM_BYTES-1 -> HOLD; cmd_valid=1 on the next cycle.
- REPEAT:
  - Byte equal to head -> rep_cnt+1. When rep_cnt reaches 3 -> HOLD with the matching type.
  - Byte not equal to head -> IDLE; err MISMATCH. The offending byte is not re-parsed as a new head.
- HOLD:
  - cmd_valid, cmd_type and cfg_params stay stable until the cycle with cmd_valid & cmd_ready; then IDLE and cmd_valid=0 on the next cycle.
  - cfg_params keeps its last value after a REPEAT command (not cleared).
  - Any rx_flag while in HOLD: byte dropped; err OVERRUN; the pending command is unaffected.
- Latency: cmd_valid rises exactly 1 cycle after the rx_flag of the final frame byte. Back-to-back frames are legal once HOLD exits.
- Timeout:
  - Counter clears on every accepted byte and in IDLE/HOLD.
  - In PARAM/REPEAT it increments each cycle without rx_flag.
  - On reaching INTER_BYTE_TIMEOUT -> IDLE; err TIMEOUT.
  - rx_flag in the same cycle as expiry: the byte wins and the counter clears.
- cmd_enable=0:
  - Bytes are ignored; PARAM/REPEAT abort to IDLE next cycle with no error.
  - HOLD is kept until the handshake completes.
- err_valid is exactly one cycle per event. If two error events coincide, the lower err_code wins (cannot happen with the FSM above; assert it).

Optional Feature:
- CMD_ERR_COUNT_EN:
  - Defined: adds output err_count [7:0]; increments on each err_valid, saturates at 255, cleared by rst only.
  - Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package mcu_cmd_pkg holds:
  - cmd_type encodings (CMD_CFG_SAVE..CMD_RESET)
  - err_code encodings
  - FSM state encodings
  - the default head-byte constants, so the controller uses identical values.
- One natural sub-module, byte_gap_timer: the inter-byte timeout counter with clear/enable inputs and an expiry strobe. The rest stays flat.

Test Plan:
- cmd_enable=1, bytes C0 00 01 1A 17 44 -> cmd_valid 1 cycle after last strobe; cmd_type=0; cfg_params=40'h00011A1744; held until cmd_ready, clears the cycle after.
- C3 C3 C3 with cmd_ready tied 1 -> single cmd_valid cycle, cmd_type=3; busy falls the cycle after.
- C1 C1 C4 -> err_valid with err_code=1 on the C4 cycle; no cmd_valid; the following byte 55 gives err_code=0.
- C2 00 01, then a gap of INTER_BYTE_TIMEOUT clocks -> err_code=2 at expiry; the next C4 C4 C4 decodes to cmd_type=4. Variant: byte arriving exactly on the expiry cycle -> no error.
- Command in HOLD with cmd_ready=0, byte 12 arrives -> err_code=3; cmd_type and cfg_params unchanged; cmd_ready=1 then completes the handshake.
- rst=1 in the middle of C0 00 01, and cmd_enable dropped in the middle of C4 C4 -> IDLE with no error; a subsequent full frame decodes normally. With CMD_ERR_COUNT_EN, 300 UNKNOWN bytes -> err_count=255.
